hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard unit for a 5-stage in-order pipeline: E-stage operand forwarding,
//   load-use stall, data-memory wait/timeout handling, branch flush and a
//   saturating stall-cycle counter.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   Rs1D_i, Rs2D_i              source registers in D
//   Rs1E_i, Rs2E_i              source registers in E
//   RdE_i, RdM_i, RdW_i         destination registers in E / M / W
//   RegWriteM_i, RegWriteW_i    register-write enables in M / W
//   LoadE_i                     instruction in E is a load
//   PCSrcE_i                    taken branch / jump resolved in E
//   MemReqM_i, MemAckM_i        data-memory request in M / completion
//   ForwardAE_o, ForwardBE_o    E operand select (00 RF, 10 ALUResultM, 01 ResultW)
//   StallF_o..StallM_o          hold pipeline registers
//   FlushD_o, FlushE_o, FlushW_o bubble into pipeline registers
//   MemErr_o                    sticky memory-timeout flag
//   StallCnt_o                  saturating count of StallF_o cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic [4:0]       RdM_i,
    input  logic [4:0]       RdW_i,
    input  logic             RegWriteM_i,
    input  logic             RegWriteW_i,
    input  logic             LoadE_i,
    input  logic             PCSrcE_i,
    input  logic             MemReqM_i,
    input  logic             MemAckM_i,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             FlushW_o,
    output logic             MemErr_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    // Wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    state_t           r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_lw_stall;
    logic       w_timeout;
    logic       w_mem_wait;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // M has priority over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (we_m && rd_m == rs && rd_m != 5'd0)
            return 2'b10;
        else if (we_w && rd_w == rs && rd_w != 5'd0)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a    = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
        w_fwd_b    = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
        w_lw_stall = LoadE_i && (RdE_i != 5'd0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
        w_timeout  = (r_state == MWAIT) && (r_wait_cnt == WAIT_LAST) && !MemAckM_i;
        // Once in MWAIT the request line is ignored: the access is already
        // committed and only ack or timeout releases it.
        w_mem_wait = ((r_state == RUN)   && MemReqM_i && !MemAckM_i) ||
                     ((r_state == MWAIT) && !MemAckM_i && !w_timeout);
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        ForwardAE_o = rst_n ? w_fwd_a : 2'b00;
        ForwardBE_o = rst_n ? w_fwd_b : 2'b00;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        if (rst_n) begin
            if (w_mem_wait) begin
                // Freeze everything up to M; branch flushes are deferred
                // until the memory access completes. A coincident load-use
                // hazard is absorbed into this stall and re-evaluated later.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else begin
                StallF_o = w_lw_stall;
                StallD_o = w_lw_stall;
                // FlushD is not masked by StallD: the flush wins in D.
                FlushD_o = PCSrcE_i;
                FlushE_o = w_lw_stall | PCSrcE_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (MemReqM_i && !MemAckM_i) begin
                        r_state    <= MWAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MWAIT: begin
                    if (MemAckM_i || w_timeout)
                        r_state <= RUN;
                    else
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                default: r_state <= RUN;
            endcase

            if (w_timeout)
                r_mem_err <= 1'b1;

            if (StallF_o && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign MemErr_o   = r_mem_err;
    assign StallCnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwm, rww, lde, pcs, req, ack;
    logic [1:0] fae, fbe;
    logic sf, sd, se, sm, fd, fe, fw, merr;
    logic [CW-1:0] scnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .RegWriteM_i(rwm), .RegWriteW_i(rww), .LoadE_i(lde), .PCSrcE_i(pcs),
        .MemReqM_i(req), .MemAckM_i(ack),
        .ForwardAE_o(fae), .ForwardBE_o(fbe),
        .StallF_o(sf), .StallD_o(sd), .StallE_o(se), .StallM_o(sm),
        .FlushD_o(fd), .FlushE_o(fe), .FlushW_o(fw),
        .MemErr_o(merr), .StallCnt_o(scnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: age of the outstanding memory access (cycles it has
    // already been stalled), sticky error, stall-cycle count.
    int m_age = 0;
    bit m_err = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return lde && rde != 0 && (rde == rs1d || rde == rs2d);
    endfunction

    // An access stalls until acked, but for at most MT cycles in total;
    // once started it keeps stalling whatever the request line does.
    function automatic bit ref_mw();
        if (ack) return 1'b0;
        if (m_age > 0) return m_age < MT;
        return req;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ref_ctl();
        bit lw = ref_lw();
        if (ref_mw()) return 7'b1111001;
        return {lw, lw, 1'b0, 1'b0, pcs, lw | pcs, 1'b0};
    endfunction

    task automatic check_outs(input string tag);
        #1;
        if (!rst_n) begin
            chk({tag, "_fa"}, 32'(fae), 0);
            chk({tag, "_fb"}, 32'(fbe), 0);
            chk({tag, "_ctl"}, 32'({sf, sd, se, sm, fd, fe, fw}), 0);
        end else begin
            chk({tag, "_fa"}, 32'(fae), 32'(ref_fwd(rs1e)));
            chk({tag, "_fb"}, 32'(fbe), 32'(ref_fwd(rs2e)));
            chk({tag, "_ctl"}, 32'({sf, sd, se, sm, fd, fe, fw}), 32'(ref_ctl()));
        end
        chk({tag, "_err"}, 32'(merr), 32'(m_err));
        chk({tag, "_cnt"}, 32'(scnt), 32'(m_cnt));
    endtask

    task automatic clk_edge();
        bit mw, stall;
        mw = ref_mw();
        stall = mw | ref_lw();
        @(posedge clk);
        if (rst_n) begin
            if (stall && m_cnt < CNT_MAX) m_cnt++;
            if (m_age == MT && !ack) m_err = 1'b1;
            m_age = mw ? m_age + 1 : 0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_age = 0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic quiet();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rwm = 0; rww = 0; lde = 0; pcs = 0; req = 0; ack = 0;
    endtask

    task automatic randomize_in();
        rs1d = 5'($urandom_range(0, 7)); rs2d = 5'($urandom_range(0, 7));
        rs1e = 5'($urandom_range(0, 7)); rs2e = 5'($urandom_range(0, 7));
        rde  = 5'($urandom_range(0, 7)); rdm  = 5'($urandom_range(0, 7));
        rdw  = 5'($urandom_range(0, 7));
        rwm = 1'($urandom); rww = 1'($urandom); lde = 1'($urandom);
        pcs = ($urandom_range(0, 3) == 0);
        req = ($urandom_range(0, 2) == 0);
        ack = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int c0;

    initial begin
        // Reset state with inputs that would otherwise forward/stall.
        quiet();
        rst_n = 1'b0;
        rwm = 1; rdm = 5; rs1e = 5; rs2e = 5; lde = 1; rde = 3; rs1d = 3;
        pcs = 1; req = 1;
        check_outs("rst");
        clk_edge();
        check_outs("rst2");
        rst_n = 1'b1;

        // Forward priority.
        quiet();
        rwm = 1; rww = 1; rdm = 5; rdw = 5; rs1e = 5;
        check_outs("fwdMW"); chk("fwdMW_k", 32'(fae), 2);
        rdm = 0;
        check_outs("fwdW"); chk("fwdW_k", 32'(fae), 1);
        rs1e = 0; rdw = 0;
        check_outs("fwd0"); chk("fwd0_k", 32'(fae), 0);
        rs2e = 9; rdw = 9;
        check_outs("fwdB"); chk("fwdB_k", 32'(fbe), 1);
        clk_edge();

        // Load-use, then RdE = 0 gives no stall.
        quiet();
        lde = 1; rde = 7; rs2d = 7;
        c0 = int'(scnt);
        check_outs("lw"); chk("lw_k", 32'({sf, sd, fe}), 32'h7);
        clk_edge();
        chk("lw_cnt", 32'(scnt), 32'(c0 + 1));
        rde = 0; rs2d = 0;
        check_outs("lw0"); chk("lw0_k", 32'({sf, sd, fe}), 0);
        clk_edge();

        // Memory wait of 3 cycles with a pending branch, released by ack.
        quiet();
        req = 1; pcs = 1;
        c0 = int'(scnt);
        for (int i = 0; i < 3; i++) begin
            check_outs("mw");
            chk("mw_k", 32'({sf, sd, se, sm, fw, fd, fe}), 32'b1111100);
            clk_edge();
        end
        ack = 1;
        check_outs("mwack");
        chk("mwack_k", 32'({sf, sd, se, sm, fw, fd, fe}), 32'b0000011);
        clk_edge();
        chk("mw_cnt", 32'(scnt), 32'(c0 + 3));
        quiet(); check_outs("mwrun");
        clk_edge();

        // Timeout: ack never arrives.
        do_reset();
        quiet();
        req = 1;
        for (int i = 0; i < MT; i++) begin
            check_outs("to");
            chk("to_k", 32'(sf), 1);
            clk_edge();
        end
        check_outs("torel"); chk("torel_k", 32'(sf), 0);
        chk("toerr0", 32'(merr), 0);
        clk_edge();
        chk("toerr1", 32'(merr), 1);
        req = 0;
        for (int i = 0; i < 3; i++) begin check_outs("tostk"); clk_edge(); end
        chk("toerr2", 32'(merr), 1);

        // Async reset in the middle of MWAIT.
        quiet(); req = 1;
        check_outs("ar0"); clk_edge();
        check_outs("ar1");
        #2 rst_n = 1'b0; model_reset();
        check_outs("arlow");
        chk("arlow_k", 32'({sf, fw, merr, scnt}), 0);
        @(negedge clk);
        rst_n = 1'b1; ack = 1;
        check_outs("arrel"); chk("arrel_k", 32'(sf), 0);
        clk_edge();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            randomize_in();
            check_outs("rnd");
            clk_edge();
        end

        // Counter saturation under a persistent load-use hazard.
        quiet(); lde = 1; rde = 4; rs1d = 4;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            check_outs("sat");
            clk_edge();
        end
        chk("sat_k", 32'(scnt), CNT_MAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
